// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed by a small byte FIFO.
// Bytes pushed with valid_i/ready_o are queued, then serialised LSB first
// with one start and one stop bit. Back-to-back frames leave no idle gap.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n_i,
  input  logic [7:0]                    data_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          push;
  logic          pop;
  logic          fifo_nonempty;

  // Transmit engine
  state_t        state_q;
  state_t        state_d;
  logic [BW-1:0] baud_q;
  logic [BW-1:0] baud_d;
  logic [2:0]    bit_q;
  logic [2:0]    bit_d;
  logic [7:0]    shift_q;
  logic [7:0]    shift_d;
  logic          tx_q;
  logic          tx_d;
  logic          baud_end;

  // A full FIFO refuses a push even if the engine pops on the same edge.
  assign ready_o       = (count_q != FULL);
  assign push          = valid_i & ready_o;
  assign fifo_nonempty = (count_q != '0);
  assign baud_end      = (baud_q == BAUD_LAST);

  assign count_o = count_q;
  assign tx_o    = tx_q;
  assign busy_o  = (state_q != IDLE);

  // Byte storage: written at the tail on every accepted push.
  // NOTE: the data array has no reset; pointers and count define which
  // entries are valid, so clearing the storage itself buys nothing.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= data_i;
    end
  end

  // FIFO pointers and occupancy; push and pop together leave count unchanged.
  // NOTE: sequential state always uses non-blocking assignment so every
  // register samples the values from before the edge.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // Next-state logic: baud timing, bit sequencing and FIFO pops.
  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_end ? '0 : baud_q + BW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;

    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        if (fifo_nonempty) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr_q];
          state_d = START;
        end
      end

      START: begin
        if (baud_end) begin
          bit_d   = '0;
          state_d = DATA;
        end
      end

      DATA: begin
        if (baud_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end

      STOP: begin
        if (baud_end) begin
          if (fifo_nonempty) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr_q];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Line level for the state being entered, so tx_o changes with the state.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // Engine registers; reset aborts any frame and parks the line high.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo at CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Stimulus pushes expected bytes into a scoreboard queue; a line monitor
// captures each 40-cycle frame from tx_o and compares it against the queue.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk;
  logic       rst_n_i;
  logic [7:0] data_i;
  logic       valid_i;
  logic       ready_o;
  logic       tx_o;
  logic       busy_o;
  logic [2:0] count_o;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];

  uart_tx_fifo #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk    (clk),
    .rst_n_i(rst_n_i),
    .data_i (data_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .tx_o   (tx_o),
    .busy_o (busy_o),
    .count_o(count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Expected per-cycle line level for one 8N1 frame of byte b.
  function automatic logic [FRAME-1:0] frame_pattern(input logic [7:0] b);
    logic [FRAME-1:0] p;
    for (int k = 0; k < FRAME; k++) begin
      int bp;
      bp = k / CPB;
      if (bp == 0)      p[k] = 1'b0;
      else if (bp == 9) p[k] = 1'b1;
      else              p[k] = b[bp-1];
    end
    return p;
  endfunction

  // Line monitor: a low level while not in a frame starts a capture of
  // FRAME samples (one per cycle, taken at the falling clock edge).
  logic [FRAME-1:0] got_tx;
  logic [FRAME-1:0] got_busy;
  int               mon_idx = 0;
  logic             in_frame = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n_i) begin
        in_frame = 1'b0;
      end else if (in_frame) begin
        got_tx[mon_idx]   = tx_o;
        got_busy[mon_idx] = busy_o;
        mon_idx++;
        if (mon_idx == FRAME) begin
          in_frame = 1'b0;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got line %0h with no byte queued", got_tx);
          end else begin
            logic [7:0] b;
            b = exp_q.pop_front();
            check($sformatf("frame_tx_%02h", b), 64'(got_tx), 64'(frame_pattern(b)));
            check($sformatf("frame_busy_%02h", b), 64'(got_busy), 64'({FRAME{1'b1}}));
          end
        end
      end else if (tx_o == 1'b0) begin
        in_frame    = 1'b1;
        got_tx      = '0;
        got_busy    = '0;
        got_tx[0]   = tx_o;
        got_busy[0] = busy_o;
        mon_idx     = 1;
      end
    end
  end

  // Burst statistics sampled at falling edges while enabled.
  logic meas_en   = 1'b0;
  logic prev_busy = 1'b0;
  int   meas_busy = 0;
  int   meas_high = 0;
  int   meas_falls = 0;
  int   meas_peak = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (meas_en) begin
        if (busy_o) meas_busy++;
        if (busy_o && tx_o) meas_high++;
        if (prev_busy && !busy_o) meas_falls++;
        if (int'(count_o) > meas_peak) meas_peak = int'(count_o);
        prev_busy = busy_o;
      end
    end
  end

  // Present a byte at a falling edge and hold it until accepted; the
  // number of falling edges spent waiting for ready_o is returned.
  task automatic push(input logic [7:0] b, output int waited);
    @(negedge clk);
    data_i  = b;
    valid_i = 1'b1;
    waited  = 0;
    while (!ready_o && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("push_ready", 64'(ready_o), 64'd1);
    @(posedge clk);
    exp_q.push_back(b);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy_o && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", 64'(busy_o), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int n;

    data_i  = 8'h00;
    valid_i = 1'b0;
    rst_n_i = 1'b1;
    #2 rst_n_i = 1'b0;
    #1;
    check("rst_tx", 64'(tx_o), 64'd1);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_ready", 64'(ready_o), 64'd1);
    repeat (3) @(negedge clk);
    rst_n_i = 1'b1;

    // Single byte 0xA5 into an idle, empty transmitter.
    push(8'hA5, w);
    @(negedge clk);
    valid_i = 1'b0;
    check("single_e0_tx", 64'(tx_o), 64'd1);
    check("single_e0_count", 64'(count_o), 64'd1);
    check("single_e0_busy", 64'(busy_o), 64'd0);
    @(negedge clk);
    check("single_e1_tx", 64'(tx_o), 64'd0);
    check("single_e1_busy", 64'(busy_o), 64'd1);
    check("single_e1_count", 64'(count_o), 64'd0);
    n = 0;
    while (busy_o && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("single_busy_len", 64'(n), 64'd40);
    check("single_tx_after", 64'(tx_o), 64'd1);
    repeat (3) @(negedge clk);

    // Back-to-back bytes, plus a push landing on the pop edge at count 2.
    meas_busy  = 0;
    meas_high  = 0;
    meas_falls = 0;
    meas_peak  = 0;
    prev_busy  = 1'b0;
    meas_en    = 1'b1;
    push(8'h01, w);
    push(8'h02, w);
    push(8'h03, w);
    @(negedge clk);
    valid_i = 1'b0;
    check("b2b_count_after3", 64'(count_o), 64'd2);
    repeat (37) @(negedge clk);
    push(8'h04, w);
    @(negedge clk);
    valid_i = 1'b0;
    check("pushpop_count2", 64'(count_o), 64'd2);
    wait_idle(400);
    @(negedge clk);
    meas_en = 1'b0;
    check("b2b_busy_cycles", 64'(meas_busy), 64'd160);
    check("b2b_busy_falls", 64'(meas_falls), 64'd1);
    check("b2b_tx_high", 64'(meas_high), 64'd36);
    check("b2b_count_peak", 64'(meas_peak), 64'd2);
    repeat (3) @(negedge clk);

    // Fill the FIFO with valid_i held; the sixth byte waits for a pop.
    push(8'h10, w);
    push(8'h11, w);
    push(8'h12, w);
    push(8'h13, w);
    push(8'h14, w);
    @(negedge clk);
    check("full_count", 64'(count_o), 64'd4);
    check("full_ready", 64'(ready_o), 64'd0);
    push(8'h15, w);
    check("full_wait_edges", 64'(w), 64'd36);
    @(negedge clk);
    valid_i = 1'b0;
    check("full_count_refill", 64'(count_o), 64'd4);
    wait_idle(1000);
    repeat (3) @(negedge clk);

    // Reset while data bit 3 (a 0) of 0xF0 is on the line.
    push(8'hF0, w);
    push(8'h3C, w);
    @(negedge clk);
    valid_i = 1'b0;
    repeat (17) @(negedge clk);
    check("pre_rst_tx", 64'(tx_o), 64'd0);
    check("pre_rst_count", 64'(count_o), 64'd1);
    #2 rst_n_i = 1'b0;
    #1;
    exp_q.delete();
    check("mid_rst_tx", 64'(tx_o), 64'd1);
    check("mid_rst_busy", 64'(busy_o), 64'd0);
    check("mid_rst_count", 64'(count_o), 64'd0);
    check("mid_rst_ready", 64'(ready_o), 64'd1);
    data_i  = 8'h77;
    valid_i = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_no_push", 64'(count_o), 64'd0);
    data_i  = 8'h66;
    rst_n_i = 1'b1;
    @(posedge clk);
    exp_q.push_back(8'h66);
    @(negedge clk);
    valid_i = 1'b0;
    check("post_rst_accept", 64'(count_o), 64'd1);
    @(negedge clk);
    wait_idle(200);
    repeat (3) @(negedge clk);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 10416, meaning clock cycles per serial bit (9600 baud at 100 MHz); legal range 2..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning byte FIFO entries; legal values are powers of two from 2 to 16.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n_i, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port data_i, input, 8 bits: byte to transmit.
REQ-006 SHALL have port valid_i, input, 1 bit: data_i is valid.
REQ-007 SHALL have port ready_o, output, 1 bit: FIFO can accept a byte this cycle.
REQ-008 SHALL have port tx_o, output, 1 bit: serial line, idle high; drives UART_RXD_OUT at top level.
REQ-009 SHALL have port busy_o, output, 1 bit: a frame is in progress.
REQ-010 SHALL have port count_o, output, $clog2(FIFO_DEPTH)+1 bits: number of bytes held in the FIFO.

Function
REQ-011 SHALL accept a byte on any rising edge where valid_i=1 and ready_o=1; the byte is written to the FIFO tail on that edge.
REQ-012 SHALL drive ready_o = (count_o != FIFO_DEPTH) combinationally; a push on a full FIFO is not accepted, even when a pop occurs on the same edge.
REQ-013 SHALL, on an edge with both an accepted push and a pop, keep count_o unchanged and preserve FIFO order.
REQ-014 SHALL use FSM states IDLE, START, DATA, STOP.
REQ-015 SHALL pop the FIFO head in IDLE when count_o>0, load it into the shift register, and move to START on that edge.
REQ-016 SHALL register tx_o, so tx_o falls on the edge that enters START: two edges after the accepting edge when idle with an empty FIFO.
REQ-017 SHALL hold each bit (start, 8 data, stop) on tx_o for exactly CLKS_PER_BIT cycles, timed by a baud counter counting 0..CLKS_PER_BIT-1 and cleared on every state transition.
REQ-018 SHALL send the start bit as 0, then data LSB first, then one stop bit as 1 (8N1); frame length is exactly 10*CLKS_PER_BIT cycles.
REQ-019 SHALL use a 3-bit bit counter in DATA, wrapping from 7 into STOP.
REQ-020 SHALL, at the end of STOP, go directly to START and pop the next byte if count_o>0 (no idle gap between back-to-back frames); otherwise it SHALL go to IDLE.
REQ-021 SHALL assert busy_o in START, DATA and STOP, and deassert it in IDLE.
REQ-022 SHALL leave an in-flight frame unaffected by later pushes and by changes on data_i.
REQ-023 SHALL keep tx_o=1 in IDLE.

Reset
REQ-024 SHALL, while rst_n_i=0, immediately force: state IDLE, tx_o=1, busy_o=0, count_o=0, ready_o=1, FIFO pointers 0, baud counter 0, bit counter 0, shift register 0.
REQ-025 SHALL, on reset asserted mid-frame, abort the frame, discard all FIFO contents, and return tx_o high without glitching low.
REQ-026 SHALL respond to no push while rst_n_i=0, and SHALL accept a push on the first rising edge after release.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-027 Single byte: push 0xA5 when idle -> tx_o low 2 edges later, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then stop high; busy_o high for exactly 40 cycles.
REQ-028 Back-to-back: push 0x01, 0x02, 0x03 on consecutive cycles -> three frames with no high gap between a stop bit and the next start bit; count_o peaks at 2.
REQ-029 Full FIFO: push 6 bytes with valid_i held -> ready_o low when count_o=4; the 6th byte is accepted only after a pop; bytes are transmitted in push order.
REQ-030 Simultaneous push and pop at count_o=4 -> push refused; at count_o=2 -> count_o stays 2.
REQ-031 Reset mid-frame during data bit 3 -> tx_o=1, busy_o=0, count_o=0 asynchronously; a push after release produces a clean full frame.
REQ-032 Loopback with the existing UART receiver at CLKS_PER_BIT=10416 -> each transmitted byte is received intact and shown on LED[7:0].
